icache_wbuf: RTL and testbench

//  Parametrised successor of the fetch-side local instruction memory. Byte-addressable

---
 rtl/icache_wbuf_pkg.sv | 20 ++
 rtl/icache_wbuf_fifo.sv | 96 +++++++++
 rtl/icache_wbuf.sv | 139 +++++++++++++
 tb/tb_icache_wbuf.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_wbuf_pkg.sv
// Shared definitions for the instruction memory with write buffer:
// access size codes and the size-to-byte-mask helper.
package icache_wbuf_pkg;

    typedef logic [3:0] byte_mask_t;

    localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
    localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
    localparam logic [2:0] ACCESS_SZ_WORD = 3'd2;

    // Any code other than byte/half is treated as a full word.
    function automatic byte_mask_t size_to_mask(input logic [2:0] sz);
        case (sz)
            ACCESS_SZ_BYTE: size_to_mask = 4'b0001;
            ACCESS_SZ_HALF: size_to_mask = 4'b0011;
            default:        size_to_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/icache_wbuf_fifo.sv
// Write FIFO: entry storage, pointers, occupancy count, and the per-byte
// forwarding network that returns the youngest queued value for each of the
// four bytes starting at fwd_addr.
module icache_wbuf_fifo
    import icache_wbuf_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    localparam int PTR_W   = $clog2(WB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [31:0]       push_data,
    input  byte_mask_t        push_mask,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [31:0]       head_data,
    output byte_mask_t        head_mask,
    output logic [PTR_W:0]    count,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic [3:0]        fwd_hit,
    output logic [31:0]       fwd_data
);

    logic [ADDR_W-1:0] addr_mem [WB_DEPTH];
    logic [31:0]       data_mem [WB_DEPTH];
    byte_mask_t        mask_mem [WB_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;

    // Entry payload; occupancy lives in the pointers, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
            mask_mem[wr_ptr_reg] <= push_mask;
        end
    end

    // Pointers wrap naturally at WB_DEPTH; count tracks push/pop balance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count     = count_reg;
    assign head_addr = addr_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign head_mask = mask_mem[rd_ptr_reg];

    for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
        logic [ADDR_W-1:0] byte_addr;
        logic [ADDR_W-1:0] diff;
        logic [PTR_W-1:0]  idx;
        logic              hit_k;
        logic [7:0]        data_k;

        assign byte_addr = fwd_addr + ADDR_W'(gi);

        // Walk entries oldest to youngest so the youngest covering entry wins.
        always_comb begin
            hit_k  = 1'b0;
            data_k = 8'h00;
            idx    = '0;
            diff   = '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                idx  = rd_ptr_reg + PTR_W'(i);
                diff = byte_addr - addr_mem[idx];
                if (((PTR_W+1)'(i) < count_reg) && (diff < ADDR_W'(4)) &&
                    mask_mem[idx][diff[1:0]]) begin
                    hit_k  = 1'b1;
                    data_k = data_mem[idx][{diff[1:0], 3'b000} +: 8];
                end
            end
        end

        assign fwd_hit[gi]          = hit_k;
        assign fwd_data[gi*8 +: 8]  = data_k;
    end

endmodule

// File: rtl/icache_wbuf.sv
// Fetch-side instruction memory: byte-addressable RAM (four byte-wide banks so
// unaligned words read in one cycle) behind a small write FIFO. Reads take two
// cycles and see queued writes through byte-merged forwarding; the FIFO drains
// one entry per cycle only when no read is requested.
module icache_wbuf
    import icache_wbuf_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int WB_DEPTH  = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata,
    output logic              hit,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [2:0]        wsz,
    output logic              wready,
    output logic              wb_empty
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int ROWS  = MEM_BYTES / 4;
    localparam int ROW_W = $clog2(ROWS);

    logic [PTR_W:0]    wb_count;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data;
    byte_mask_t        head_mask;
    logic [3:0]        fwd_hit;
    logic [31:0]       fwd_data;
    logic              accept;
    logic              drain;
    logic              read_in_range;
    logic [31:0]       bank_q;
    logic [31:0]       merged;

    logic              s1_valid_reg;
    logic [1:0]        s1_off_reg;
    logic [3:0]        s1_fwd_hit_reg;
    logic [31:0]       s1_fwd_data_reg;
    logic              hit_reg;
    logic [31:0]       rdata_reg;

    // Fetch has priority: drain only in cycles without a read. A full FIFO
    // refuses writes even while draining, so wready depends only on count.
    assign wready        = (wb_count != (PTR_W+1)'(WB_DEPTH));
    assign wb_empty      = (wb_count == '0);
    assign accept        = we && wready;
    assign drain         = !re && (wb_count != '0);
    assign read_in_range = (({1'b0, raddr} + (ADDR_W+1)'(3)) < (ADDR_W+1)'(MEM_BYTES));

    icache_wbuf_fifo #(
        .WB_DEPTH (WB_DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_addr (waddr),
        .push_data (wdata),
        .push_mask (size_to_mask(wsz)),
        .pop       (drain),
        .head_addr (head_addr),
        .head_data (head_data),
        .head_mask (head_mask),
        .count     (wb_count),
        .fwd_addr  (raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        logic [7:0]       mem [ROWS];
        logic [7:0]       q_reg;
        logic [1:0]       wr_k;
        logic [ROW_W-1:0] rd_row;
        logic [ROW_W-1:0] wr_row;
        logic             wr_en;

        // Bank gi holds byte (gi - offset) of the access; lanes below the
        // offset belong to the next row.
        assign rd_row = raddr[ROW_W+1:2] + ROW_W'(2'(gi) < raddr[1:0]);
        assign wr_row = head_addr[ROW_W+1:2] + ROW_W'(2'(gi) < head_addr[1:0]);
        assign wr_k   = 2'(gi) - head_addr[1:0];
        assign wr_en  = drain && head_mask[wr_k] &&
                        (({1'b0, head_addr} + (ADDR_W+1)'(wr_k)) < (ADDR_W+1)'(MEM_BYTES));

        // Single-port bank: drain writes never coincide with a read.
        always_ff @(posedge clk) begin
            if (wr_en)
                mem[wr_row] <= head_data[{wr_k, 3'b000} +: 8];
            else if (re)
                q_reg <= mem[rd_row];
        end

        assign bank_q[gi*8 +: 8] = q_reg;

        // Byte gi of the result comes from the bank at lane (offset + gi).
        logic [1:0] lane;
        assign lane = s1_off_reg + 2'(gi);
        assign merged[gi*8 +: 8] = s1_fwd_hit_reg[gi] ? s1_fwd_data_reg[gi*8 +: 8]
                                                      : bank_q[{lane, 3'b000} +: 8];
    end

    // Stage 1: capture forwarding snapshot alongside the bank read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_off_reg      <= 2'd0;
            s1_fwd_hit_reg  <= 4'd0;
            s1_fwd_data_reg <= 32'd0;
        end else begin
            s1_valid_reg    <= re && read_in_range;
            s1_off_reg      <= raddr[1:0];
            s1_fwd_hit_reg  <= fwd_hit;
            s1_fwd_data_reg <= fwd_data;
        end
    end

    // Stage 2: merge forwarded and RAM bytes; misses and idle cycles give zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            hit_reg   <= s1_valid_reg;
            rdata_reg <= s1_valid_reg ? merged : 32'd0;
        end
    end

    assign hit   = hit_reg;
    assign rdata = rdata_reg;

endmodule

// File: tb/tb_icache_wbuf.sv
// Self-checking bench for icache_wbuf: directed scenarios plus a randomized
// run, all compared against a byte-array + write-queue reference model.
module tb_icache_wbuf;
    import icache_wbuf_pkg::*;

    localparam int MEM_BYTES = 8192;
    localparam int WB_DEPTH  = 4;
    localparam int ADDR_W    = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0;
    logic [31:0] raddr = '0, waddr = '0, wdata = '0;
    logic [2:0]  wsz = '0;
    logic [31:0] rdata;
    logic        hit, wready, wb_empty;

    icache_wbuf #(.MEM_BYTES(MEM_BYTES), .WB_DEPTH(WB_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .re(re), .raddr(raddr), .rdata(rdata), .hit(hit),
        .we(we), .waddr(waddr), .wdata(wdata), .wsz(wsz), .wready(wready), .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    ent_t        wq[$];
    logic [7:0]  mem_model [MEM_BYTES];
    logic        s1_hit = 1'b0, exp_hit = 1'b0;
    logic [31:0] s1_rdata = '0, exp_rdata = '0;
    int          n_checks = 0, n_pass = 0;

    function automatic logic [3:0] mask_of(input logic [2:0] sz);
        if (sz == ACCESS_SZ_BYTE) return 4'b0001;
        if (sz == ACCESS_SZ_HALF) return 4'b0011;
        return 4'b1111;
    endfunction

    // Each byte: RAM value unless some queued write covers it; later entries win.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        if (64'(a) + 64'd3 >= 64'(MEM_BYTES)) return 32'h0;
        for (int k = 0; k < 4; k++) begin
            b = mem_model[int'(a) + k];
            foreach (wq[i])
                for (int j = 0; j < 4; j++)
                    if (wq[i].mask[j] && ((wq[i].addr + 32'(j)) == (a + 32'(k))))
                        b = wq[i].data[8*j +: 8];
            r[8*k +: 8] = b;
        end
        return r;
    endfunction

    function automatic void model_drain();
        ent_t e;
        e = wq.pop_front();
        for (int j = 0; j < 4; j++)
            if (e.mask[j] && (64'(e.addr) + 64'(j) < 64'(MEM_BYTES)))
                mem_model[int'(e.addr) + j] = e.data[8*j +: 8];
    endfunction

    function automatic void model_reset();
        wq.delete();
        s1_hit = 1'b0; s1_rdata = '0;
        exp_hit = 1'b0; exp_rdata = '0;
    endfunction

    // One clock of stimulus; advances the model and leaves outputs expected
    // at the current time in exp_hit / exp_rdata.
    task automatic cycle(input logic r, input logic [31:0] ra, input logic w,
                         input logic [31:0] wa, input logic [31:0] wd,
                         input logic [2:0] sz, output logic acc);
        logic        nh;
        logic [31:0] nd;
        ent_t        e;
        acc = w && (wq.size() < WB_DEPTH);
        nh  = r && (64'(ra) + 64'd3 < 64'(MEM_BYTES));
        nd  = nh ? model_read(ra) : 32'h0;
        if (!r && wq.size() > 0) model_drain();
        if (acc) begin
            e.addr = wa; e.data = wd; e.mask = mask_of(sz);
            wq.push_back(e);
        end
        re = r; raddr = ra; we = w; waddr = wa; wdata = wd; wsz = sz;
        @(posedge clk); #1;
        exp_hit = s1_hit; exp_rdata = s1_rdata;
        s1_hit = nh; s1_rdata = nd;
        re = 1'b0; we = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cycle(1'b0, '0, 1'b0, '0, '0, '0, a);
    endtask

    task automatic read_addr(input logic [31:0] a);
        logic x;
        cycle(1'b1, a, 1'b0, '0, '0, '0, x);
        cycle(1'b0, '0, 1'b0, '0, '0, '0, x);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", hit); else n_pass++;
        n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
        n_checks++; if (wready !== 1'b1) $display("FAIL reset_wready: got %b want 1", wready); else n_pass++;
        n_checks++; if (wb_empty !== 1'b1) $display("FAIL reset_wb_empty: got %b want 1", wb_empty); else n_pass++;
        @(negedge clk); rst = 1'b0;
        $display("reset: hit=%b rdata=%h wready=%b wb_empty=%b", hit, rdata, wready, wb_empty);
    endtask

    // Zero the whole RAM through the write port so the model has known contents.
    task automatic init_ram();
        logic acc;
        int   i = 0, tries = 0;
        while (i < MEM_BYTES / 4 && tries < 3 * MEM_BYTES) begin
            cycle(1'b0, '0, 1'b1, 32'(i * 4), 32'h0, ACCESS_SZ_WORD, acc);
            if (acc) i++;
            tries++;
        end
        idle(WB_DEPTH + 1);
        n_checks++;
        if (i != MEM_BYTES / 4 || wb_empty !== 1'b1)
            $display("FAIL init_ram: words=%0d wb_empty=%b want %0d/1", i, wb_empty, MEM_BYTES / 4);
        else n_pass++;
        $display("init_ram: %0d words in %0d cycles", i, tries);
    endtask

    task automatic test_preload_read();
        logic acc;
        cycle(1'b0, '0, 1'b1, 32'h0, 32'h11223344, ACCESS_SZ_WORD, acc);
        idle(3);
        rst = 1'b1; model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        read_addr(32'h0);
        n_checks++; if (hit !== 1'b1) $display("FAIL preload_hit: got %b want 1", hit); else n_pass++;
        n_checks++; if (rdata !== 32'h11223344) $display("FAIL preload_rdata: got %h want 11223344", rdata); else n_pass++;
        $display("preload read 0x0: hit=%b rdata=%h", hit, rdata);
    endtask

    task automatic test_forward_word();
        logic acc;
        cycle(1'b1, 32'h10, 1'b1, 32'h10, 32'hAABBCCDD, ACCESS_SZ_WORD, acc);
        cycle(1'b1, 32'h10, 1'b0, '0, '0, '0, acc);
        n_checks++; if (rdata !== 32'h0) $display("FAIL fwd_same_cycle: got %h want 00000000", rdata); else n_pass++;
        cycle(1'b1, 32'h10, 1'b0, '0, '0, '0, acc);
        n_checks++; if (rdata !== 32'hAABBCCDD || hit !== 1'b1)
            $display("FAIL fwd_word: got %h/%b want aabbccdd/1", rdata, hit); else n_pass++;
        n_checks++; if (wb_empty !== 1'b0) $display("FAIL fwd_not_drained: got wb_empty=%b want 0", wb_empty); else n_pass++;
        $display("forward 0x10: rdata=%h wb_empty=%b", rdata, wb_empty);
    endtask

    task automatic test_youngest_merge();
        logic acc;
        idle(WB_DEPTH + 1);
        cycle(1'b1, 32'h20, 1'b1, 32'h20, 32'h11111111, ACCESS_SZ_WORD, acc);
        cycle(1'b1, 32'h20, 1'b1, 32'h21, 32'h00000022, ACCESS_SZ_BYTE, acc);
        cycle(1'b1, 32'h20, 1'b1, 32'h22, 32'h00004433, ACCESS_SZ_HALF, acc);
        cycle(1'b1, 32'h20, 1'b0, '0, '0, '0, acc);
        cycle(1'b1, 32'h20, 1'b0, '0, '0, '0, acc);
        n_checks++; if (rdata !== 32'h44332211) $display("FAIL merge_fifo: got %h want 44332211", rdata); else n_pass++;
        idle(WB_DEPTH + 1);
        n_checks++; if (wb_empty !== 1'b1) $display("FAIL merge_drained: got wb_empty=%b want 1", wb_empty); else n_pass++;
        read_addr(32'h20);
        n_checks++; if (rdata !== 32'h44332211) $display("FAIL merge_ram: got %h want 44332211", rdata); else n_pass++;
        $display("merge 0x20: rdata=%h", rdata);
    endtask

    task automatic test_full_drain();
        logic        acc;
        logic [31:0] d5;
        d5 = $urandom;
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h30, 1'b1, 32'h40 + 32'(4 * i), $urandom, ACCESS_SZ_WORD, acc);
        n_checks++; if (wready !== 1'b0) $display("FAIL full_wready: got %b want 0", wready); else n_pass++;
        cycle(1'b1, 32'h30, 1'b1, 32'h50, d5, ACCESS_SZ_WORD, acc);
        n_checks++; if (wready !== 1'b0) $display("FAIL full_starved: got %b want 0", wready); else n_pass++;
        cycle(1'b0, '0, 1'b1, 32'h50, d5, ACCESS_SZ_WORD, acc);
        n_checks++; if (wready !== 1'b1) $display("FAIL drain_wready: got %b want 1", wready); else n_pass++;
        cycle(1'b0, '0, 1'b1, 32'h50, d5, ACCESS_SZ_WORD, acc);
        idle(2);
        n_checks++; if (wb_empty !== 1'b0) $display("FAIL drain_4idle: got wb_empty=%b want 0", wb_empty); else n_pass++;
        idle(1);
        n_checks++; if (wb_empty !== 1'b1) $display("FAIL drain_5idle: got wb_empty=%b want 1", wb_empty); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            read_addr(32'h40 + 32'(4 * i));
            n_checks++;
            if (rdata !== exp_rdata) $display("FAIL drain_data[%0d]: got %h want %h", i, rdata, exp_rdata);
            else n_pass++;
        end
        $display("full/drain: last word %h", rdata);
    endtask

    task automatic test_range();
        logic acc;
        read_addr(32'h1FFE);
        n_checks++; if (hit !== 1'b0 || rdata !== 32'h0)
            $display("FAIL range_miss: got %b/%h want 0/00000000", hit, rdata); else n_pass++;
        cycle(1'b0, '0, 1'b1, 32'h1FFE, 32'hDEADBEEF, ACCESS_SZ_WORD, acc);
        idle(2);
        read_addr(32'h1FFC);
        n_checks++; if (hit !== 1'b1 || rdata !== 32'hBEEF0000)
            $display("FAIL range_top: got %b/%h want 1/beef0000", hit, rdata); else n_pass++;
        read_addr(32'h0);
        n_checks++; if (rdata !== 32'h11223344) $display("FAIL range_alias: got %h want 11223344", rdata); else n_pass++;
        $display("range: top word %h", rdata);
    endtask

    task automatic test_reset_mid_drain();
        logic acc;
        cycle(1'b1, 32'h0, 1'b1, 32'h100, 32'hA1A2A3A4, ACCESS_SZ_WORD, acc);
        cycle(1'b1, 32'h0, 1'b1, 32'h104, 32'hB1B2B3B4, ACCESS_SZ_WORD, acc);
        cycle(1'b1, 32'h0, 1'b1, 32'h108, 32'hC1C2C3C4, ACCESS_SZ_WORD, acc);
        cycle(1'b0, '0, 1'b0, '0, '0, '0, acc);
        rst = 1'b1; #1;
        model_reset();
        n_checks++; if (hit !== 1'b0 || rdata !== 32'h0)
            $display("FAIL rst_mid_out: got %b/%h want 0/00000000", hit, rdata); else n_pass++;
        n_checks++; if (wb_empty !== 1'b1 || wready !== 1'b1)
            $display("FAIL rst_mid_fifo: got empty=%b ready=%b want 1/1", wb_empty, wready); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        read_addr(32'h100);
        n_checks++; if (rdata !== 32'hA1A2A3A4) $display("FAIL rst_mid_drained: got %h want a1a2a3a4", rdata); else n_pass++;
        read_addr(32'h104);
        n_checks++; if (rdata !== 32'h0) $display("FAIL rst_mid_lost1: got %h want 00000000", rdata); else n_pass++;
        read_addr(32'h108);
        n_checks++; if (rdata !== 32'h0) $display("FAIL rst_mid_lost2: got %h want 00000000", rdata); else n_pass++;
        $display("reset mid-drain: 0x108 reads %h", rdata);
    endtask

    task automatic test_random();
        logic        r, w, acc;
        logic [31:0] ra, wa, wd;
        logic [2:0]  sz;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 9) < 6);
            ra = ($urandom_range(0, 7) == 0) ? 32'h1FF8 + $urandom_range(0, 7) : 32'h40 + $urandom_range(0, 31);
            w  = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 7) == 0) ? 32'h1FFC + $urandom_range(0, 7) : 32'h40 + $urandom_range(0, 31);
            wd = $urandom;
            sz = 3'($urandom_range(0, 3));
            cycle(r, ra, w, wa, wd, sz, acc);
            n_checks++; if (hit !== exp_hit) $display("FAIL rand_hit[%0d]: got %b want %b", i, hit, exp_hit); else n_pass++;
            n_checks++; if (rdata !== exp_rdata) $display("FAIL rand_rdata[%0d]: got %h want %h", i, rdata, exp_rdata); else n_pass++;
            n_checks++; if (wready !== (wq.size() < WB_DEPTH))
                $display("FAIL rand_wready[%0d]: got %b want %b", i, wready, wq.size() < WB_DEPTH); else n_pass++;
            n_checks++; if (wb_empty !== (wq.size() == 0))
                $display("FAIL rand_wb_empty[%0d]: got %b want %b", i, wb_empty, wq.size() == 0); else n_pass++;
            $display("rand %0d: re=%b ra=%h we=%b wa=%h sz=%0d acc=%b -> hit=%b rdata=%h",
                     i, r, ra, w, wa, sz, acc, hit, rdata);
        end
    endtask

    initial begin
        test_reset();
        init_ram();
        test_preload_read();
        test_forward_word();
        test_youngest_merge();
        test_full_drain();
        test_range();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
